// File: rtl/fifo_defines_pkg.sv
// Shared constants and types for the generator sample FIFO.
//   DATA_WIDTH : sample width (signed, two's complement)
//   FIFO_DEPTH : default FIFO depth (entries, power of two)
//   FIFO_PTR_W : pointer/count width, one wrap bit above the index
//   fifo_ptr_t : pointer/count type at the default depth
package fifo_defines_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH) + 1;

    typedef logic [FIFO_PTR_W-1:0] fifo_ptr_t;

endpackage : fifo_defines_pkg

// File: rtl/gen_sample_fifo_if.sv
// Sample stream bus between funct_generator/consumer and gen_sample_fifo.
//   wr_en_i, data_i    : write strobe and sample from the generator
//   rd_en_i            : read request from the consumer
//   clr_err_i          : clears the sticky error bits
//   data_o, rd_valid_o : registered read sample and its valid strobe
// master = generator/consumer side, slave = FIFO side.
interface gen_sample_fifo_if
    import fifo_defines_pkg::*;
#(
    parameter int unsigned DW = DATA_WIDTH
) ();

    logic                 wr_en_i;
    logic signed [DW-1:0] data_i;
    logic                 rd_en_i;
    logic                 clr_err_i;
    logic signed [DW-1:0] data_o;
    logic                 rd_valid_o;

    modport master (
        output wr_en_i, data_i, rd_en_i, clr_err_i,
        input  data_o, rd_valid_o
    );

    modport slave (
        input  wr_en_i, data_i, rd_en_i, clr_err_i,
        output data_o, rd_valid_o
    );

endinterface : gen_sample_fifo_if

// File: rtl/gen_fifo_ram.sv
// Simple dual-port sample store: synchronous write, synchronous registered read.
//   clk, rst          : clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i      : read port; rdata_o updates on the edge after re_i
//   rdata_o           : registered read data, holds when re_i is low
module gen_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: same-address write in the same cycle returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : gen_fifo_ram

// File: rtl/gen_sample_fifo.sv
// Sample FIFO directly downstream of funct_generator.
//   clk, rst        : clock, async active-low reset
//   bus (slave)     : write strobe/sample in, read request, error clear,
//                     registered read sample and rd_valid out
//   full_o/empty_o/almost_full_o/almost_empty_o : registered level flags
//   count_o         : occupancy
//   overflow_o/underflow_o : sticky error bits
//   watermark_o     : peak occupancy, present only with FIFO_WATERMARK_EN
module gen_sample_fifo #(
    parameter int unsigned DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = fifo_defines_pkg::FIFO_DEPTH,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 4,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    gen_sample_fifo_if.slave    bus,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [CW-1:0]       count_o,
    output logic                overflow_o,
`ifdef FIFO_WATERMARK_EN
    output logic [CW-1:0]       watermark_o,
`endif
    output logic                underflow_o
);

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, af_q, ae_q;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          rd_valid_q;
    logic          rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] rdata;

    // Acceptance uses registered flags only, so no input reaches an output combinationally.
    assign rd_acc = bus.rd_en_i & ~empty_q;
    assign wr_acc = bus.wr_en_i & (~full_q | rd_acc);

    // Next pointers, occupancy and sticky errors; a new error beats a clear.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = bus.clr_err_i ? 1'b0 : ovf_q;
        udf_d    = bus.clr_err_i ? 1'b0 : udf_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
        if (bus.wr_en_i && !wr_acc) begin
            ovf_d = 1'b1;
        end
        if (bus.rd_en_i && !rd_acc) begin
            udf_d = 1'b1;
        end
    end

    // State registers; flags are registered decodes of the next occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CW'(DEPTH));
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= CW'(AF_THRESH));
            ae_q       <= (count_d <= CW'(AE_THRESH));
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_acc;
        end
    end

`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] wm_q;

    // Peak occupancy; a clear restarts tracking from the current level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wm_q <= '0;
        end else if (bus.clr_err_i) begin
            wm_q <= count_q;
        end else if (count_q > wm_q) begin
            wm_q <= count_q;
        end
    end

    assign watermark_o = wm_q;
`endif

    gen_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.data_i),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign bus.data_o     = rdata;
    assign bus.rd_valid_o = rd_valid_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

endmodule : gen_sample_fifo

// File: tb/tb_gen_sample_fifo.sv
// Directed self-checking bench for gen_sample_fifo (DEPTH=16, DATA_WIDTH=16).
module tb_gen_sample_fifo;

    logic       clk;
    logic       rst;
    logic       full, empty, af, ae, ovf, udf;
    logic [4:0] count;
`ifdef FIFO_WATERMARK_EN
    logic [4:0] watermark;
`endif

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    gen_sample_fifo_if bus ();

    gen_sample_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (af),
        .almost_empty_o (ae),
        .count_o        (count),
        .overflow_o     (ovf),
`ifdef FIFO_WATERMARK_EN
        .watermark_o    (watermark),
`endif
        .underflow_o    (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] d;
        logic        rd;
        logic        clr;
        logic [4:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic        valid;
        logic [15:0] dout;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs[35];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic wr, input logic [15:0] d, input logic rd, input logic clr);
        bus.wr_en_i   = wr;
        bus.data_i    = d;
        bus.rd_en_i   = rd;
        bus.clr_err_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_flags(input string name, input int idx, input logic [4:0] c);
        chk({name, ".count"}, idx, 32'(count), 32'(c));
        chk({name, ".full"},  idx, 32'(full),  32'(c == 5'd16));
        chk({name, ".empty"}, idx, 32'(empty), 32'(c == 5'd0));
        chk({name, ".af"},    idx, 32'(af),    32'(c >= 5'd12));
        chk({name, ".ae"},    idx, 32'(ae),    32'(c <= 5'd4));
    endtask

    initial begin
        int k;
        logic [4:0] c;

        // Table for fill-to-overflow, drain-to-underflow, then error clear.
        for (int i = 0; i < 17; i++) begin
            k = i + 1;
            c = (k > 16) ? 5'd16 : 5'(k);
            vecs[i] = '{wr: 1'b1, d: 16'(k), rd: 1'b0, clr: 1'b0, cnt: c,
                        full: (c == 5'd16), empty: 1'b0, af: (c >= 5'd12), ae: (c <= 5'd4),
                        valid: 1'b0, dout: 16'h0, ovf: (k == 17), udf: 1'b0};
        end
        for (int j = 1; j <= 17; j++) begin
            c = (j > 16) ? 5'd0 : 5'(16 - j);
            vecs[16 + j] = '{wr: 1'b0, d: 16'h0, rd: 1'b1, clr: 1'b0, cnt: c,
                             full: (c == 5'd16), empty: (c == 5'd0), af: (c >= 5'd12), ae: (c <= 5'd4),
                             valid: (j <= 16), dout: (j <= 16) ? 16'(j) : 16'h0010,
                             ovf: 1'b1, udf: (j == 17)};
        end
        vecs[34] = '{wr: 1'b0, d: 16'h0, rd: 1'b0, clr: 1'b1, cnt: 5'd0,
                     full: 1'b0, empty: 1'b1, af: 1'b0, ae: 1'b1,
                     valid: 1'b0, dout: 16'h0010, ovf: 1'b0, udf: 1'b0};

        bus.wr_en_i   = 1'b0;
        bus.data_i    = '0;
        bus.rd_en_i   = 1'b0;
        bus.clr_err_i = 1'b0;
        rst           = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk_flags("reset", 0, 5'd0);
        chk("reset.valid", 0, 32'(bus.rd_valid_o), 32'h0);
        chk("reset.data",  0, 32'($unsigned(bus.data_o)), 32'h0);
        chk("reset.ovf",   0, 32'(ovf), 32'h0);
        chk("reset.udf",   0, 32'(udf), 32'h0);
`ifdef FIFO_WATERMARK_EN
        chk("reset.wm",    0, 32'(watermark), 32'h0);
`endif
        rst = 1'b1;

        // Tests 1-2: table-driven fill and drain
        for (int i = 0; i < 35; i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
            chk("tbl.count", i, 32'(count), 32'(vecs[i].cnt));
            chk("tbl.full",  i, 32'(full),  32'(vecs[i].full));
            chk("tbl.empty", i, 32'(empty), 32'(vecs[i].empty));
            chk("tbl.af",    i, 32'(af),    32'(vecs[i].af));
            chk("tbl.ae",    i, 32'(ae),    32'(vecs[i].ae));
            chk("tbl.valid", i, 32'(bus.rd_valid_o), 32'(vecs[i].valid));
            chk("tbl.data",  i, 32'($unsigned(bus.data_o)), 32'(vecs[i].dout));
            chk("tbl.ovf",   i, 32'(ovf), 32'(vecs[i].ovf));
            chk("tbl.udf",   i, 32'(udf), 32'(vecs[i].udf));
        end

        // Test 3: full with simultaneous write and read
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b0);
        step(1'b1, 16'h7FFF, 1'b1, 1'b0);
        chk_flags("t3.both", 0, 5'd16);
        chk("t3.ovf",   0, 32'(ovf), 32'h0);
        chk("t3.valid", 0, 32'(bus.rd_valid_o), 32'h1);
        chk("t3.data",  0, 32'($unsigned(bus.data_o)), 32'h0001);
        for (int j = 0; j < 16; j++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk("t3.rd_valid", j, 32'(bus.rd_valid_o), 32'h1);
            chk("t3.rd_data",  j, 32'($unsigned(bus.data_o)), (j == 15) ? 32'h7FFF : 32'(j + 2));
        end
        chk_flags("t3.end", 0, 5'd0);

        // Test 4: empty with simultaneous write and read
        step(1'b1, 16'h8000, 1'b1, 1'b0);
        chk_flags("t4.both", 0, 5'd1);
        chk("t4.udf",   0, 32'(udf), 32'h1);
        chk("t4.valid", 0, 32'(bus.rd_valid_o), 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t4.valid", 1, 32'(bus.rd_valid_o), 32'h1);
        chk("t4.data",  1, 32'($unsigned(bus.data_o)), 32'h8000);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t4.clr_udf", 0, 32'(udf), 32'h0);

        // Test 5: interleaved pairs across pointer wraps
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
            chk("t5.wr_count", i, 32'(count), 32'h1);
            step(1'b0, 16'h0, 1'b1, 1'b0);
            chk("t5.rd_count", i, 32'(count), 32'h0);
            chk("t5.rd_valid", i, 32'(bus.rd_valid_o), 32'h1);
            chk("t5.rd_data",  i, 32'($unsigned(bus.data_o)), 32'(16'h0100 + i));
        end
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'h1234, 1'b0, 1'b1);
        chk("t5.clr_vs_ovf", 0, 32'(ovf), 32'h1);
        chk("t5.full_count", 0, 32'(count), 32'd16);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("t5.clr_ovf", 0, 32'(ovf), 32'h0);

        // Test 6: asynchronous reset mid-burst at count 9
        rst = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b0);
        step(1'b1, 16'h0AAA, 1'b1, 1'b0);
        chk_flags("t6.pre", 0, 5'd9);
        chk("t6.pre_data", 0, 32'($unsigned(bus.data_o)), 32'h0001);
`ifdef FIFO_WATERMARK_EN
        chk("t6.pre_wm", 0, 32'(watermark), 32'd9);
`endif
        bus.wr_en_i = 1'b1;
        bus.rd_en_i = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk_flags("t6.async", 0, 5'd0);
        chk("t6.data",  0, 32'($unsigned(bus.data_o)), 32'h0);
        chk("t6.valid", 0, 32'(bus.rd_valid_o), 32'h0);
`ifdef FIFO_WATERMARK_EN
        chk("t6.wm", 0, 32'(watermark), 32'h0);
`endif
        step(1'b0, 16'h0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk_flags("t6.post", 0, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_gen_sample_fifo
